fir4_inv_u: RTL
===============

Name: fir4_inv_u

Overview:
Inverse (decoder) for the team's 4-tap moving-sum FIR: takes the (w+2)-bit sum stream y[k] = x[k]+x[k-1]+x[k-2]+x[k-3] and recovers the original w-bit samples x[k].
- Recurrence: x[k] = y[k] - y[k-1] + x[k-4], zero initial state.
- Sits at the receive/check end of the FIR datapath, used for loopback verification and stream reconstruction.
- Detects any recovered value outside the w-bit range, flags it as a stream fault, and holds until resynchronised.

Parameters:
w, 16, width of recovered sample; input sum is w+2 bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_sum carries a new sum sample this cycle
in_sum  input  w+2  unsigned moving-sum sample y[k]
err_clr  input  1  clear fault and resynchronise state to zero
out_valid  output  1  out_data carries a recovered sample
out_data  output  w  recovered sample x[k], unsigned
err  output  1  sticky fault flag

Behaviour:
- Reset: asynchronous and active-high. Clears all registers immediately, not on the clock edge: out_valid=0, out_data=0, err=0, y_prev=0, history h1..h4=0, state=RUN.
- State: y_prev (w+2), history h1..h4 (w each, h1 newest recovered sample), state in {RUN, FAULT}.
- Arithmetic, combinational from registered state:
  - d = in_sum - y_prev, signed w+3.
  - r = d + h4, signed w+4, no truncation.
  - in_range = (r >= 0) && (r <= 2^w-1).
- Latency: 1 cycle. out_valid and out_data are registered.
- out_valid is a single-cycle pulse per accepted sample. No backpressure. out_data holds its last value when out_valid=0.
- RUN, in_valid=1, in_range=1:
  - out_data<=r[w-1:0], out_valid<=1, y_prev<=in_sum.
  - Shift history: h4<=h3, h3<=h2, h2<=h1, h1<=r[w-1:0].
- RUN, in_valid=1, in_range=0:
  - out_valid<=0, err<=1, state<=FAULT.
  - y_prev and history are not updated.
- RUN, in_valid=0: out_valid<=0. All other state holds. Idle gaps do not affect the recurrence.
- FAULT:
  - in_valid is ignored and out_valid stays 0.
  - err stays 1 until err_clr.
- err_clr=1, in any state, highest priority below reset:
  - Next edge: y_prev, h1..h4 <= 0; err<=0; state<=RUN; out_valid<=0.
  - A simultaneous in_valid sample is dropped.
- Wrap-around: none. All widths are sized so no internal overflow is possible. Any out-of-range result is treated as a fault, never wrapped.
- Reset mid-operation:
  - All in-flight state is lost.
  - The decoder assumes the encoder is reset in step, since both start from an all-zero history.

Decomposition:
- Shared package fir4_pkg:
  - typedef enum {RUN, FAULT} fir4_inv_state_t
  - localparam TAPS=4
  - sum width function/constant w+2
- One sub-module, fir4_hist: a TAPS-deep w-bit shift register with shift-enable and synchronous clear, providing h4. It is reused by future FIR blocks.
- Adder/subtractor stays inline behavioural.

Test Plan:
- w=16, release reset; in_sum 1,3,6,10,14 on consecutive valid cycles -> out_data 1,2,3,4,5, each with out_valid=1 one cycle after its input; err=0.
- in_sum 65535,131070,196605,262140,262140 -> out_data 65535 five times (max-range boundary, no fault).
- Same stream as test 1 with 0-3 idle cycles (in_valid=0) between samples -> identical out_data sequence; out_valid pulses only one cycle after each valid input.
- After reset, in_sum 5 then 2 -> out_data 5; then r=-3, so err=1 and out_valid=0; further in_sum 9,9 produce no output; err stays 1.
- From FAULT: pulse err_clr with in_valid=1 and in_sum=7 -> sample dropped; err=0 next cycle. Then in_sum 7 -> out_data 7.
- Mid-stream (after test 1's third output), assert reset between clock edges -> out_valid, out_data, err go 0 immediately. After release, in_sum 4 -> out_data 4 (history was cleared).

Source files
------------

// File: rtl/fir4_pkg.sv
// Shared definitions for the 4-tap moving-sum FIR family.
package fir4_pkg;
    localparam int TAPS = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fir4_inv_state_t;

    // A sum of TAPS w-bit samples needs two extra bits.
    function automatic int sum_w(input int w);
        return w + 2;
    endfunction
endpackage

// File: rtl/fir4_hist.sv
// DEPTH-deep sample history; taps[0] is newest, oldest is DEPTH samples back.
module fir4_hist
    import fir4_pkg::*;
#(
    parameter int w     = 16,
    parameter int DEPTH = TAPS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         shift,
    input  logic [w-1:0] din,
    output logic [w-1:0] oldest
);
    logic [DEPTH-1:0][w-1:0] taps;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            taps <= '0;
        else if (clr)
            taps <= '0;
        else if (shift)
            taps <= {taps[DEPTH-2:0], din};
    end

    assign oldest = taps[DEPTH-1];
endmodule

// File: rtl/fir4_inv_u.sv
// Decoder for the 4-tap moving sum: x[k] = y[k] - y[k-1] + x[k-4], with
// out-of-range results latched as a sticky stream fault.
module fir4_inv_u
    import fir4_pkg::*;
#(
    parameter int w = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [w+1:0] in_sum,
    input  logic         err_clr,
    output logic         out_valid,
    output logic [w-1:0] out_data,
    output logic         err
);
    localparam int SW = sum_w(w);

    fir4_inv_state_t  state;
    logic [SW-1:0]    y_prev;
    logic [w-1:0]     h4;
    logic signed [w+2:0] d;
    logic signed [w+3:0] r;
    logic             in_range;
    logic             accept;

    // Widths chosen so neither the difference nor the sum can overflow.
    assign d        = $signed({1'b0, in_sum}) - $signed({1'b0, y_prev});
    assign r        = $signed({d[w+2], d}) + $signed({4'b0000, h4});
    assign in_range = (r[w+3:w] == 4'b0000);
    assign accept   = !err_clr && (state == RUN) && in_valid && in_range;

    fir4_hist #(.w(w), .DEPTH(TAPS)) u_hist (
        .clk    (clk),
        .reset  (reset),
        .clr    (err_clr),
        .shift  (accept),
        .din    (r[w-1:0]),
        .oldest (h4)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            y_prev    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else if (err_clr) begin
            state     <= RUN;
            y_prev    <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (in_valid) begin
                        if (in_range) begin
                            out_valid <= 1'b1;
                            out_data  <= r[w-1:0];
                            y_prev    <= in_sum;
                        end else begin
                            err   <= 1'b1;
                            state <= FAULT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
